seg7_capture: RTL and testbench

Sequential receiver for a multiplexed 7-segment display bus: it samples the segment lines and the one-hot digit-select lines and recovers the 3-bit value shown on each digit. It uses the same 0–7 glyph set and polarity convention as the display drivers in this codebase. It sits on the board-test and loopback path, where it checks what the display driver actually emits. A per-digit value register is written only after a segment pattern has held steady for a programmable number of cycles. Any pattern outside the glyph set raises a sticky error.

---
 rtl/seg7_capture_if.sv | 26 ++
 rtl/seg7_capture.sv | 138 +++++++++++++
 tb/tb_seg7_capture.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/seg7_capture_if.sv
// Display bus seen by the capture block: segment lines, digit selects,
// error clear, and the recovered per-digit values and status.
interface seg7_capture_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      i_a, i_b, i_c, i_d, i_e, i_f, i_g;
    logic [NUM_DIGITS-1:0]     i_dig;
    logic                      i_clr_err;
    logic [3*NUM_DIGITS-1:0]   o_value;
    logic [NUM_DIGITS-1:0]     o_digit_valid;
    logic                      o_update;
    logic                      o_err;
    logic [2:0]                o_err_digit;

    // Bus driver side (display driver under test / bench)
    modport master (
        output i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_dig, i_clr_err,
        input  o_value, o_digit_valid, o_update, o_err, o_err_digit
    );

    // Capture block side
    modport slave (
        input  i_a, i_b, i_c, i_d, i_e, i_f, i_g, i_dig, i_clr_err,
        output o_value, o_digit_valid, o_update, o_err, o_err_digit
    );
endinterface

// File: rtl/seg7_capture.sv
// Multiplexed 7-segment bus receiver: recovers the 0-7 value shown on each
// digit once the {digit, segments} sample has been stable long enough.
module seg7_capture #(
    parameter int COMMON_ANODE_CATHODE = 1,
    parameter int NUM_DIGITS           = 4,
    parameter int STABLE_CYCLES        = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    seg7_capture_if.slave bus
);
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

    state_t                    state;
    logic [CW-1:0]             cnt;
    logic [NUM_DIGITS-1:0]     dig_q, dig_p;
    logic [6:0]                seg_q, seg_p;
    logic [6:0]                seg_raw, seg_norm;
    logic                      onehot, same, legal;
    logic [2:0]                dec;
    logic [3*NUM_DIGITS-1:0]   value_r;
    logic [NUM_DIGITS-1:0]     valid_r;
    logic                      update_r, err_r;
    logic [2:0]                err_digit_r;

    // Lit segments read as 1 after normalisation, {a..g} with a as MSB
    assign seg_raw  = {bus.i_a, bus.i_b, bus.i_c, bus.i_d, bus.i_e, bus.i_f, bus.i_g};
    assign seg_norm = (COMMON_ANODE_CATHODE != 0) ? seg_raw : ~seg_raw;

    assign onehot = (dig_q != '0) && ((dig_q & (dig_q - 1'b1)) == '0);
    assign same   = (dig_q == dig_p) && (seg_q == seg_p);

    // Glyph decode of the registered sample; all-off and other shapes are illegal
    always_comb begin
        legal = 1'b1;
        dec   = 3'd0;
        case (seg_q)
            7'b1111110: dec = 3'd0;
            7'b0110000: dec = 3'd1;
            7'b1101101: dec = 3'd2;
            7'b1111001: dec = 3'd3;
            7'b0110011: dec = 3'd4;
            7'b1011011: dec = 3'd5;
            7'b1011111: dec = 3'd6;
            7'b1110000: dec = 3'd7;
            default:    legal = 1'b0;
        endcase
    end

    // Input/previous-sample registers, stability FSM and capture outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dig_q       <= '0;
            seg_q       <= '0;
            dig_p       <= '0;
            seg_p       <= '0;
            state       <= IDLE;
            cnt         <= '0;
            value_r     <= '0;
            valid_r     <= '0;
            update_r    <= 1'b0;
            err_r       <= 1'b0;
            err_digit_r <= 3'd0;
        end else begin
            dig_q    <= bus.i_dig;
            seg_q    <= seg_norm;
            dig_p    <= dig_q;
            seg_p    <= seg_q;
            update_r <= 1'b0;

            // Clear first so an error accept in this same cycle overrides it
            if (bus.i_clr_err) begin
                err_r       <= 1'b0;
                err_digit_r <= 3'd0;
            end

            case (state)
                IDLE: begin
                    if (onehot) begin
                        state <= SETTLE;
                        cnt   <= CW'(1);
                    end else begin
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (!onehot) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!same) begin
                        cnt   <= CW'(1);
                    end else if (cnt >= CW'(STABLE_CYCLES - 1)) begin
                        // Stable long enough: accept into the selected slot
                        state <= LOCKED;
                        cnt   <= CW'(STABLE_CYCLES);
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (dig_q[i]) begin
                                if (legal) begin
                                    value_r[3*i +: 3] <= dec;
                                    valid_r[i]        <= 1'b1;
                                    update_r          <= !valid_r[i] || (value_r[3*i +: 3] != dec);
                                end else begin
                                    err_r             <= 1'b1;
                                    err_digit_r       <= 3'(i);
                                end
                            end
                        end
                    end else begin
                        cnt   <= cnt + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!same) begin
                        if (onehot) begin
                            state <= SETTLE;
                            cnt   <= CW'(1);
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.o_value       = value_r;
    assign bus.o_digit_valid = valid_r;
    assign bus.o_update      = update_r;
    assign bus.o_err         = err_r;
    assign bus.o_err_digit   = err_digit_r;
endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: one active-high-segment instance and one
// active-low instance share the same raw stimulus.
module tb_seg7_capture;
    localparam logic [6:0] G1 = 7'b0110000;
    localparam logic [6:0] G2 = 7'b1101101;
    localparam logic [6:0] G3 = 7'b1111001;
    localparam logic [6:0] G4 = 7'b0110011;
    localparam logic [6:0] G5 = 7'b1011011;
    localparam logic [6:0] G6 = 7'b1011111;
    localparam logic [6:0] G7 = 7'b1110000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_checks = 0;
    int   pulses = 0;
    int   saw3 = 0;

    seg7_capture_if #(.NUM_DIGITS(4)) bus_h ();
    seg7_capture_if #(.NUM_DIGITS(4)) bus_l ();

    seg7_capture #(.COMMON_ANODE_CATHODE(1), .NUM_DIGITS(4), .STABLE_CYCLES(4)) dut_h (
        .i_clk(clk), .i_rst(rst), .bus(bus_h.slave)
    );
    seg7_capture #(.COMMON_ANODE_CATHODE(0), .NUM_DIGITS(4), .STABLE_CYCLES(4)) dut_l (
        .i_clk(clk), .i_rst(rst), .bus(bus_l.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus_h.o_update === 1'b1) pulses++;
            if (bus_h.o_digit_valid[1] === 1'b1 && bus_h.o_value[5:3] === 3'd3) saw3++;
        end
    endtask

    task automatic drive(input logic [3:0] dig, input logic [6:0] seg);
        {bus_h.i_a, bus_h.i_b, bus_h.i_c, bus_h.i_d, bus_h.i_e, bus_h.i_f, bus_h.i_g} = seg;
        {bus_l.i_a, bus_l.i_b, bus_l.i_c, bus_l.i_d, bus_l.i_e, bus_l.i_f, bus_l.i_g} = seg;
        bus_h.i_dig = dig;
        bus_l.i_dig = dig;
    endtask

    task automatic set_clr(input logic v);
        bus_h.i_clr_err = v;
        bus_l.i_clr_err = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(4'b0000, 7'b0000000);
        set_clr(1'b0);
        tick(2);
        rst = 1'b0;
        pulses = 0;
        saw3 = 0;
    endtask

    function automatic logic [31:0] outs_h();
        return {13'd0, bus_h.o_err_digit, bus_h.o_err, bus_h.o_update,
                bus_h.o_digit_valid, bus_h.o_value};
    endfunction

    initial begin
        set_clr(1'b0);
        drive(4'b0001, G5);

        // Reset and first capture: glyph 5 on digit 0
        rst = 1'b1;
        tick(1);
        check("reset_outs_1", outs_h(), 32'd0);
        tick(1);
        check("reset_outs_2", outs_h(), 32'd0);
        rst = 1'b0;
        pulses = 0;
        tick(4);
        check("first_no_early_valid", {31'd0, bus_h.o_digit_valid[0]}, 32'd0);
        check("first_no_early_pulse", pulses, 0);
        tick(1);
        check("first_value", bus_h.o_value[2:0], 3'd5);
        check("first_valid", bus_h.o_digit_valid, 4'b0001);
        check("first_update", bus_h.o_update, 1'b1);
        tick(1);
        check("first_update_one_cycle", bus_h.o_update, 1'b0);

        // Polarity: raw 0000001 on digit 2
        do_reset();
        drive(4'b0100, 7'b0000001);
        tick(5);
        check("pol_low_value", bus_l.o_value[8:6], 3'd0);
        check("pol_low_valid", bus_l.o_digit_valid, 4'b0100);
        check("pol_low_noerr", bus_l.o_err, 1'b0);
        check("pol_high_err", bus_h.o_err, 1'b1);
        check("pol_high_err_digit", bus_h.o_err_digit, 3'd2);
        check("pol_high_valid", bus_h.o_digit_valid, 4'b0000);

        // Glitch rejection: 3 for three samples then steady 7 on digit 1
        do_reset();
        drive(4'b0010, G3);
        tick(3);
        drive(4'b0010, G7);
        tick(10);
        check("glitch_pulses", pulses, 1);
        check("glitch_never3", saw3, 0);
        check("glitch_value", bus_h.o_value[5:3], 3'd7);
        check("glitch_valid", bus_h.o_digit_valid, 4'b0010);

        // Multiplexed scan: digits show 1,2,6,4; three full scans
        do_reset();
        for (int s = 0; s < 3; s++) begin
            drive(4'b0001, G1); tick(6);
            drive(4'b0010, G2); tick(6);
            drive(4'b0100, G6); tick(6);
            drive(4'b1000, G4); tick(6);
            if (s == 0) check("scan_pulses_first", pulses, 4);
        end
        check("scan_value", bus_h.o_value, 12'b100_110_010_001);
        check("scan_valid", bus_h.o_digit_valid, 4'b1111);
        check("scan_pulses_total", pulses, 4);
        check("scan_noerr", bus_h.o_err, 1'b0);

        // Blanking then illegal glyph with clear in the accept cycle
        do_reset();
        drive(4'b0011, G1);
        tick(6);
        drive(4'b0000, G1);
        tick(6);
        check("blank_noerr", bus_h.o_err, 1'b0);
        check("blank_novalid", bus_h.o_digit_valid, 4'b0000);
        check("blank_pulses", pulses, 0);
        drive(4'b1000, 7'b0000000);
        tick(4);
        check("illegal_not_yet", bus_h.o_err, 1'b0);
        set_clr(1'b1);
        tick(1);
        set_clr(1'b0);
        check("illegal_set_wins", bus_h.o_err, 1'b1);
        check("illegal_err_digit", bus_h.o_err_digit, 3'd3);
        check("illegal_slot_kept", bus_h.o_digit_valid, 4'b0000);
        check("illegal_no_update", pulses, 0);
        set_clr(1'b1);
        tick(1);
        set_clr(1'b0);
        check("clr_err", bus_h.o_err, 1'b0);
        check("clr_err_digit", bus_h.o_err_digit, 3'd0);

        // Reset after 2 of 4 stable samples, then a fresh pattern
        do_reset();
        drive(4'b0001, G2);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst_outs", outs_h(), 32'd0);
        rst = 1'b0;
        drive(4'b0100, G6);
        tick(4);
        check("midrst_no_accept", outs_h(), 32'd0);
        tick(1);
        check("midrst_fresh_value", bus_h.o_value, 12'b000_110_000_000);
        check("midrst_fresh_valid", bus_h.o_digit_valid, 4'b0100);
        check("midrst_fresh_update", bus_h.o_update, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
